uart_bus_bridge: RTL and testbench

UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

---
 rtl/uart_bus_bridge.sv | 183 ++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_bridge.sv
// Byte-stream to bus bridge: decodes 'R'/'W' frames from a UART receiver, runs one
// bus cycle per frame and streams ACK/NAK or read data back through the transmitter.
module uart_bus_bridge #(
    parameter int BUS_TIMEOUT_WIDTH = 8
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_ready_i,
    output logic        rx_ack_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_write_o,
    input  logic        tx_busy_i,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_dtw_o,
    input  logic [31:0] bus_dtr_i,
    output logic        bus_rw_o,
    output logic        bus_stb_o,
    input  logic        bus_ack_i
);
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] BYTE_ACK  = 8'h06;
    localparam logic [7:0] BYTE_NAK  = 8'h15;
    localparam logic [BUS_TIMEOUT_WIDTH-1:0] TIMER_ONE = BUS_TIMEOUT_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP, TXWAIT, RXWAIT} state_t;

    state_t                       state_reg, state_next;
    state_t                       resume_reg, resume_next;
    logic                         rw_reg, rw_next;
    logic [1:0]                   byte_cnt_reg, byte_cnt_next;
    logic [31:0]                  addr_reg, addr_next;
    logic [31:0]                  data_reg, data_next;
    logic [BUS_TIMEOUT_WIDTH-1:0] bus_timer_reg, bus_timer_next;
    logic [BUS_TIMEOUT_WIDTH-1:0] bus_timer_inc;
    logic                         bus_timeout;
    logic [31:0]                  resp_word_reg, resp_word_next;
    logic [2:0]                   resp_left_reg, resp_left_next;
    logic [1:0]                   tx_hold_reg, tx_hold_next;
    logic                         rx_ack_reg, rx_ack_next;
    logic                         tx_write_reg, tx_write_next;
    logic [7:0]                   tx_data_reg, tx_data_next;
    logic                         is_cmd;

    // The timer expires on the cycle it would reach all-ones, so strobe lasts 2^W-1 cycles.
    assign bus_timer_inc = bus_timer_reg + TIMER_ONE;
    assign bus_timeout   = &bus_timer_inc;
    assign is_cmd        = (rx_data_i == CMD_READ) || (rx_data_i == CMD_WRITE);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_reg  <= IDLE;
            resume_reg <= IDLE;
        end else begin
            state_reg  <= state_next;
            resume_reg <= resume_next;
        end
    end

    // Every consumed byte detours through RXWAIT; resume_reg remembers where to go after.
    always_comb begin
        state_next  = state_reg;
        resume_next = resume_reg;
        case (state_reg)
            IDLE: if (rx_ready_i) begin
                state_next  = RXWAIT;
                resume_next = is_cmd ? ADDR : RESP;
            end
            ADDR: if (rx_ready_i) begin
                state_next  = RXWAIT;
                resume_next = (byte_cnt_reg != 2'd3) ? ADDR : (rw_reg ? DATA : BUS);
            end
            DATA: if (rx_ready_i) begin
                state_next  = RXWAIT;
                resume_next = (byte_cnt_reg == 2'd3) ? BUS : DATA;
            end
            RXWAIT: if (!rx_ready_i) state_next = resume_reg;
            BUS:    if (bus_ack_i || bus_timeout) state_next = RESP;
            RESP:   if (!tx_busy_i) state_next = TXWAIT;
            TXWAIT: if (tx_hold_reg == 2'd2 && !tx_busy_i)
                state_next = (resp_left_reg == 3'd0) ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rw_next        = rw_reg;
        byte_cnt_next  = byte_cnt_reg;
        addr_next      = addr_reg;
        data_next      = data_reg;
        bus_timer_next = bus_timer_reg;
        resp_word_next = resp_word_reg;
        resp_left_next = resp_left_reg;
        tx_hold_next   = tx_hold_reg;
        rx_ack_next    = 1'b0;
        tx_write_next  = 1'b0;
        tx_data_next   = tx_data_reg;
        case (state_reg)
            IDLE: if (rx_ready_i) begin
                rx_ack_next   = 1'b1;
                byte_cnt_next = 2'd0;
                if (is_cmd) begin
                    rw_next = (rx_data_i == CMD_WRITE);
                end else begin
                    resp_word_next = {BYTE_NAK, 24'h0};
                    resp_left_next = 3'd1;
                end
            end
            ADDR: if (rx_ready_i) begin
                rx_ack_next   = 1'b1;
                addr_next     = {addr_reg[23:0], rx_data_i};
                byte_cnt_next = byte_cnt_reg + 2'd1;
            end
            DATA: if (rx_ready_i) begin
                rx_ack_next   = 1'b1;
                data_next     = {data_reg[23:0], rx_data_i};
                byte_cnt_next = byte_cnt_reg + 2'd1;
            end
            BUS: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (bus_ack_i) begin
                    bus_timer_next = '0;
                    resp_word_next = rw_reg ? {BYTE_ACK, 24'h0} : bus_dtr_i;
                    resp_left_next = rw_reg ? 3'd1 : 3'd4;
                end else if (bus_timeout) begin
                    bus_timer_next = '0;
                    resp_word_next = {BYTE_NAK, 24'h0};
                    resp_left_next = 3'd1;
                end else begin
                    bus_timer_next = bus_timer_inc;
                end
            end
            RESP: if (!tx_busy_i) begin
                tx_write_next  = 1'b1;
                tx_data_next   = resp_word_reg[31:24];
                resp_word_next = {resp_word_reg[23:0], 8'h00};
                resp_left_next = resp_left_reg - 3'd1;
                tx_hold_next   = 2'd0;
            end
            // Busy is not trusted during the strobe cycle and the one after it.
            TXWAIT: if (tx_hold_reg != 2'd2) tx_hold_next = tx_hold_reg + 2'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rw_reg        <= 1'b0;
            byte_cnt_reg  <= 2'd0;
            addr_reg      <= 32'h0;
            data_reg      <= 32'h0;
            bus_timer_reg <= '0;
            resp_word_reg <= 32'h0;
            resp_left_reg <= 3'd0;
            tx_hold_reg   <= 2'd0;
            rx_ack_reg    <= 1'b0;
            tx_write_reg  <= 1'b0;
            tx_data_reg   <= 8'h00;
        end else begin
            rw_reg        <= rw_next;
            byte_cnt_reg  <= byte_cnt_next;
            addr_reg      <= addr_next;
            data_reg      <= data_next;
            bus_timer_reg <= bus_timer_next;
            resp_word_reg <= resp_word_next;
            resp_left_reg <= resp_left_next;
            tx_hold_reg   <= tx_hold_next;
            rx_ack_reg    <= rx_ack_next;
            tx_write_reg  <= tx_write_next;
            tx_data_reg   <= tx_data_next;
        end
    end

    assign rx_ack_o   = rx_ack_reg;
    assign tx_write_o = tx_write_reg;
    assign tx_data_o  = tx_data_reg;
    assign bus_addr_o = addr_reg;
    assign bus_dtw_o  = data_reg;
    assign bus_rw_o   = rw_reg;
    assign bus_stb_o  = (state_reg == BUS);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: frame-level model predicts bus cycles and TX bytes for
// directed and random frames; one monitor compares the DUT against it every cycle.
module tb_uart_bus_bridge;
    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_i;
    logic        rx_ack_o;
    logic [7:0]  tx_data_o;
    logic        tx_write_o;
    logic        tx_busy_i;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_dtw_o;
    logic [31:0] bus_dtr_i;
    logic        bus_rw_o;
    logic        bus_stb_o;
    logic        bus_ack_i;
    logic        tx_busy_model;
    logic        bp_hold;

    always #5 clock_i = ~clock_i;
    assign tx_busy_i = tx_busy_model | bp_hold;

    uart_bus_bridge #(.BUS_TIMEOUT_WIDTH(8)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .rx_data_i(rx_data_i), .rx_ready_i(rx_ready_i), .rx_ack_o(rx_ack_o),
        .tx_data_o(tx_data_o), .tx_write_o(tx_write_o), .tx_busy_i(tx_busy_i),
        .bus_addr_o(bus_addr_o), .bus_dtw_o(bus_dtw_o), .bus_dtr_i(bus_dtr_i),
        .bus_rw_o(bus_rw_o), .bus_stb_o(bus_stb_o), .bus_ack_i(bus_ack_i)
    );

    typedef struct packed { logic rw; logic [31:0] addr; logic [31:0] wdata; logic timeout; } bus_exp_t;
    typedef struct packed { logic timeout; logic [7:0] lat; logic [31:0] rdata; } plan_t;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] tx_log[$];
    bus_exp_t   bus_q[$];
    bus_exp_t   bus_log[$];
    plan_t      plan_q[$];

    int total = 0;
    int bad   = 0;
    int last_stb_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    // ---------------- frame-level model ----------------
    task automatic push_be(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) rx_q.push_back(w[8*i +: 8]);
    endtask

    task automatic add_write(input logic [31:0] a, input logic [31:0] d, input int lat);
        bus_exp_t e;
        plan_t    p;
        rx_q.push_back(8'h57); push_be(a); push_be(d);
        e = '{rw: 1'b1, addr: a, wdata: d, timeout: 1'b0};
        p = '{timeout: 1'b0, lat: 8'(lat), rdata: 32'h0};
        bus_q.push_back(e); plan_q.push_back(p);
        tx_q.push_back(8'h06);
    endtask

    task automatic add_read(input logic [31:0] a, input logic [31:0] rd, input int lat, input logic tmo);
        bus_exp_t e;
        plan_t    p;
        rx_q.push_back(8'h52); push_be(a);
        e = '{rw: 1'b0, addr: a, wdata: 32'h0, timeout: tmo};
        p = '{timeout: tmo, lat: 8'(lat), rdata: rd};
        bus_q.push_back(e); plan_q.push_back(p);
        if (tmo) tx_q.push_back(8'h15);
        else for (int i = 3; i >= 0; i--) tx_q.push_back(rd[8*i +: 8]);
    endtask

    task automatic add_bad(input logic [7:0] b);
        rx_q.push_back(b);
        tx_q.push_back(8'h15);
    endtask

    // ---------------- stimulus agents ----------------
    task automatic feed_all();
        logic [7:0] b;
        int n;
        while (rx_q.size() > 0) begin
            b = rx_q.pop_front();
            repeat ($urandom_range(0, 3)) @(negedge clock_i);
            @(negedge clock_i);
            rx_data_i  = b;
            rx_ready_i = 1'b1;
            n = 0;
            do begin
                @(negedge clock_i);
                n++;
            end while (!rx_ack_o && n < 3000);
            check("rx_byte_accepted", 32'(rx_ack_o), 32'd1);
            rx_ready_i = 1'b0;
            rx_data_i  = 8'($urandom);
            if (!rx_ack_o) rx_q.delete();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((tx_q.size() != 0 || bus_q.size() != 0) && n < 6000) begin
            @(negedge clock_i);
            n++;
        end
        check("drain_pending", 32'(tx_q.size() + bus_q.size()), 32'd0);
        repeat (20) @(negedge clock_i);
    endtask

    initial begin
        tx_busy_model = 1'b0;
        forever begin
            @(negedge clock_i);
            if (tx_write_o) begin
                tx_busy_model = 1'b1;
                repeat ($urandom_range(1, 6)) @(negedge clock_i);
                tx_busy_model = 1'b0;
            end
        end
    end

    // Bus slave follows the plan queue: ack after 'lat' cycles, or never for a timeout.
    initial begin
        plan_t p;
        int n;
        bus_ack_i = 1'b0;
        bus_dtr_i = 32'h0;
        forever begin
            @(posedge clock_i); #1;
            if (bus_stb_o && !reset_i) begin
                if (plan_q.size() > 0) begin
                    p = plan_q.pop_front();
                    if (!p.timeout) begin
                        repeat (int'(p.lat)) begin @(posedge clock_i); #1; end
                        bus_ack_i = 1'b1;
                        bus_dtr_i = p.rdata;
                        @(posedge clock_i); #1;
                        bus_ack_i = 1'b0;
                        bus_dtr_i = $urandom;
                    end
                end
                n = 0;
                while (bus_stb_o && n < 1000) begin @(posedge clock_i); #1; n++; end
            end
        end
    end

    // ---------------- compare process ----------------
    bus_exp_t   cur;
    bus_exp_t   act;
    logic [7:0] exp_b;
    logic       have_cur = 1'b0;
    logic       prev_tx = 1'b0, prev_ack = 1'b0, prev_stb = 1'b0, ack_seen = 1'b0;
    int         stb_len = 0;

    initial forever begin
        @(negedge clock_i);
        if (reset_i) begin
            prev_tx = 1'b0; prev_ack = 1'b0; prev_stb = 1'b0; ack_seen = 1'b0; have_cur = 1'b0;
        end else begin
            if (rx_ack_o) check("rx_ack_single_cycle", 32'(prev_ack), 32'd0);
            if (tx_write_o) begin
                check("tx_write_single_cycle", 32'(prev_tx), 32'd0);
                if (tx_q.size() == 0) flag("tx_unexpected", 32'(tx_data_o));
                else begin
                    exp_b = tx_q.pop_front();
                    check("tx_byte", 32'(tx_data_o), 32'(exp_b));
                end
                tx_log.push_back(tx_data_o);
            end
            if (ack_seen) check("stb_drop_after_ack", 32'(bus_stb_o), 32'd0);
            ack_seen = 1'b0;
            if (bus_stb_o && !prev_stb) begin
                act = '{rw: bus_rw_o, addr: bus_addr_o, wdata: bus_dtw_o, timeout: 1'b0};
                bus_log.push_back(act);
                stb_len = 0;
                if (bus_q.size() == 0) begin
                    flag("bus_unexpected", bus_addr_o);
                    have_cur = 1'b0;
                end else begin
                    cur = bus_q.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (bus_stb_o) begin
                stb_len++;
                if (have_cur) begin
                    check("bus_addr", bus_addr_o, cur.addr);
                    check("bus_rw", 32'(bus_rw_o), 32'(cur.rw));
                    if (cur.rw) check("bus_dtw", bus_dtw_o, cur.wdata);
                end
                if (bus_ack_i) ack_seen = 1'b1;
            end
            if (!bus_stb_o && prev_stb) begin
                last_stb_len = stb_len;
                if (have_cur && cur.timeout) check("timeout_stb_cycles", 32'(stb_len), 32'd255);
                have_cur = 1'b0;
            end
            prev_tx  = tx_write_o;
            prev_ack = rx_ack_o;
            prev_stb = bus_stb_o;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0]  lit [6];
        logic [7:0]  bb;
        logic [31:0] ra, rd;
        int k, pulses, m;

        reset_i = 1'b1; rx_ready_i = 1'b0; rx_data_i = 8'h00; bp_hold = 1'b0;
        repeat (3) @(negedge clock_i);
        check("reset_rx_ack", 32'(rx_ack_o), 32'd0);
        check("reset_tx_write", 32'(tx_write_o), 32'd0);
        check("reset_tx_data", 32'(tx_data_o), 32'd0);
        check("reset_stb", 32'(bus_stb_o), 32'd0);
        check("reset_rw", 32'(bus_rw_o), 32'd0);
        check("reset_addr", bus_addr_o, 32'd0);
        check("reset_dtw", bus_dtw_o, 32'd0);
        reset_i = 1'b0;

        // Directed write, read (ack after 3 cycles) and bad command.
        add_write(32'h0000_1000, 32'hDEAD_BEEF, 1);
        add_read(32'h0000_1000, 32'hCAFE_F00D, 3, 1'b0);
        add_bad(8'h41);
        feed_all();
        wait_idle();
        lit[0] = 8'h06; lit[1] = 8'hCA; lit[2] = 8'hFE; lit[3] = 8'hF0; lit[4] = 8'h0D; lit[5] = 8'h15;
        check("directed_tx_count", 32'(tx_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < tx_log.size(); i++) check("directed_tx_literal", 32'(tx_log[i]), 32'(lit[i]));
        check("directed_bus_count", 32'(bus_log.size()), 32'd2);
        if (bus_log.size() >= 2) begin
            check("directed_w_addr", bus_log[0].addr, 32'h0000_1000);
            check("directed_w_data", bus_log[0].wdata, 32'hDEAD_BEEF);
            check("directed_w_rw", 32'(bus_log[0].rw), 32'd1);
            check("directed_r_rw", 32'(bus_log[1].rw), 32'd0);
        end

        // Timeout: no ack, strobe must last 255 cycles and NAK follows.
        add_read(32'h0000_3000, 32'h0, 0, 1'b1);
        feed_all();
        wait_idle();
        check("timeout_len_literal", 32'(last_stb_len), 32'd255);
        check("timeout_nak_literal", 32'(tx_log[tx_log.size()-1]), 32'h15);

        // Back-pressure: transmitter busy for 50 cycles once the read completes.
        add_read(32'h0000_2000, 32'h1234_5678, 2, 1'b0);
        fork
            feed_all();
            begin
                m = 0;
                while (!bus_stb_o && m < 3000) begin @(negedge clock_i); m++; end
                while (bus_stb_o && m < 3000) begin @(negedge clock_i); m++; end
                bp_hold = 1'b1;
                pulses = 0;
                repeat (50) begin
                    @(negedge clock_i);
                    if (tx_write_o) pulses++;
                end
                bp_hold = 1'b0;
                check("backpressure_no_write", 32'(pulses), 32'd0);
            end
        join
        wait_idle();

        // Reset after the third address byte aborts the frame silently.
        rx_q.push_back(8'h52); rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33);
        feed_all();
        repeat (3) @(negedge clock_i);
        reset_i = 1'b1;
        @(negedge clock_i);
        check("midreset_stb", 32'(bus_stb_o), 32'd0);
        check("midreset_addr", bus_addr_o, 32'd0);
        check("midreset_tx_data", 32'(tx_data_o), 32'd0);
        check("midreset_rx_ack", 32'(rx_ack_o), 32'd0);
        @(negedge clock_i);
        reset_i = 1'b0;
        add_read(32'hA5A5_0001, 32'h0BAD_F00D, 1, 1'b0);
        feed_all();
        wait_idle();

        // Random frames fed back to back, so bytes also arrive during bus/response phases.
        for (int f = 0; f < 40; f++) begin
            k  = $urandom_range(0, 9);
            ra = $urandom;
            rd = $urandom;
            if (k <= 3) add_write(ra, rd, $urandom_range(0, 5));
            else if (k == 7) begin
                do bb = 8'($urandom); while (bb == 8'h52 || bb == 8'h57);
                add_bad(bb);
            end else if (k == 8) add_read(ra, rd, 0, 1'b1);
            else add_read(ra, rd, $urandom_range(0, 5), 1'b0);
        end
        feed_all();
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
